// File: rtl/pmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : pmem_responder_if
// Description : Line-granular physical-memory bus between the cache
//               controller (master) and the memory responder (slave).
//               pmem_address  byte address, bits [3:0] ignored
//               pmem_read     read request, held until pmem_resp
//               pmem_write    write request, held until pmem_resp
//               pmem_wdata    128-bit line to write
//               pmem_rdata    128-bit line read (registered in the slave)
//               pmem_resp     one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface pmem_responder_if;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : pmem_responder
// Description : Fixed-latency line store answering cache pmem requests.
//               A request accepted in IDLE completes LATENCY cycles later
//               with a one-cycle pmem_resp. Dropping the request while
//               busy aborts it silently. Handshake violations set a sticky
//               protocol_err flag.
// Ports       : clk          clock, rising edge
//               reset        synchronous active-high reset
//               pmem         slave side of the pmem bus
//               busy         high while a transaction is in flight
//               protocol_err sticky handshake-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  wire               clk,
    input  wire               reset,
    pmem_responder_if.slave   pmem,
    output logic              busy,
    output logic              protocol_err
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic            r_op_wr;
    logic [IW-1:0]   r_idx;
    logic [127:0]    r_wdata;
    logic [127:0]    r_rdata;
    logic            r_err;
    logic [127:0]    r_mem [DEPTH];

    logic            w_accept;
    logic            w_err_evt;
    logic            w_to_resp;
    logic            w_req_held;
    logic            w_flip;
    logic [IW-1:0]   w_idx;
    logic            w_unused_addr;

    assign w_idx         = pmem.pmem_address[IW+3:4];
    // Offset bits and bits above the index are don't-care by design.
    assign w_unused_addr = ^pmem.pmem_address;
    assign w_req_held    = pmem.pmem_read | pmem.pmem_write;
    // A write still asserted alongside a latched write is not a flip.
    assign w_flip        = r_op_wr ? (pmem.pmem_read & ~pmem.pmem_write)
                                   : pmem.pmem_write;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_held) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_err_evt   = pmem.pmem_read & pmem.pmem_write;
                end
            end
            S_BUSY: begin
                if (!w_req_held) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_evt = w_flip | (w_idx != r_idx);
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_to_resp = (r_state == S_BUSY) && (w_state_nxt == S_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_err_evt;
            if (w_accept) begin
                // Write takes priority when both requests are raised.
                r_op_wr <= pmem.pmem_write;
                r_idx   <= w_idx;
                r_wdata <= pmem.pmem_wdata;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_to_resp && !r_op_wr) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Line store is not reset; reset suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (!reset && w_to_resp && r_op_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign pmem.pmem_rdata = r_rdata;
    assign pmem.pmem_resp  = (r_state == S_RESP);
    assign busy            = (r_state != S_IDLE);
    assign protocol_err    = r_err;
endmodule
`default_nettype wire
